// File: rtl/ec_ctr_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ec_ctr_pkg
// Description : Shared state codes for the main controller and rd_data_ctr.
// Revision    : 1.0 - initial release
// ============================================================================
package ec_ctr_pkg;

    localparam int c_STATE_W = 3;

    typedef enum logic [2:0] {
        IDLE         = 3'd0,
        RD_DATA      = 3'd1,
        GENERATE_IND = 3'd2,
        POP_RF       = 3'd3,
        OUTPUT       = 3'd4
    } main_state_e;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_DONE  = 2'd2,
        S_HOLD  = 2'd3
    } rd_state_e;

endpackage
`default_nettype wire

// File: rtl/rd_data_ctr_if.sv
`default_nettype none
// ============================================================================
// Module      : rd_data_ctr_if
// Description : Data-memory read port and register-file write port bundle.
// Revision    : 1.0 - initial release
// ============================================================================
interface rd_data_ctr_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
);
    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_ack;
    logic [DATA_W-1:0] mem_rdata;
    logic              rf_we;
    logic [ADDR_W-1:0] rf_waddr;
    logic [DATA_W-1:0] rf_wdata;

    modport master (
        output mem_req, mem_addr, rf_we, rf_waddr, rf_wdata,
        input  mem_ack, mem_rdata
    );

    modport slave (
        input  mem_req, mem_addr, rf_we, rf_waddr, rf_wdata,
        output mem_ack, mem_rdata
    );
endinterface
`default_nettype wire

// File: rtl/rd_addr_cnt.sv
`default_nettype none
// ============================================================================
// Module      : rd_addr_cnt
// Description : Clearable, enabled word counter with terminal-count flag.
// Revision    : 1.0 - initial release
// ============================================================================
module rd_addr_cnt #(
    parameter int ADDR_W    = 4,
    parameter int NUM_WORDS = 16
) (
    input  wire               clk,
    input  wire               rst,
    input  wire               i_clr,
    input  wire               i_en,
    output logic [ADDR_W-1:0] o_count,
    output logic              o_tc
);
    localparam logic [ADDR_W-1:0] c_LAST = ADDR_W'(NUM_WORDS - 1);

    logic [ADDR_W-1:0] r_count;

    // Clear wins over enable so the last transfer leaves the counter at zero.
    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_count <= '0;
        end else if (i_en) begin
            r_count <= r_count + ADDR_W'(1);
        end
    end

    assign o_count = r_count;
    assign o_tc    = (r_count == c_LAST);
endmodule
`default_nettype wire

// File: rtl/rd_data_ctr.sv
`default_nettype none
// ============================================================================
// Module      : rd_data_ctr
// Description : Read phase: fetch NUM_WORDS words over req/ack and write them
//               to the register file. Optional macro RD_DATA_CHECKSUM_EN adds
//               a running chk_sum output.
// Revision    : 1.0 - initial release
// ============================================================================
module rd_data_ctr
    import ec_ctr_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int NUM_WORDS = 16,
    parameter int ADDR_W    = 4
) (
    input  wire                   clk,
    input  wire                   rst,
    input  wire [c_STATE_W-1:0]   current_state,
    rd_data_ctr_if.master         bus,
    output logic                  rd_done
`ifdef RD_DATA_CHECKSUM_EN
    ,
    output logic [DATA_W-1:0]     chk_sum
`endif
);
    rd_state_e         r_state;
    rd_state_e         w_state_nxt;
    logic              w_run;
    logic              w_xfer;
    logic              w_req_nxt;
    logic              w_done_nxt;
    logic              w_cnt_clr;
    logic              w_cnt_en;
    logic [ADDR_W-1:0] w_count;
    logic              w_tc;

    logic              r_mem_req;
    logic              r_rf_we;
    logic              r_rd_done;
    logic [ADDR_W-1:0] r_rf_waddr;
    logic [DATA_W-1:0] r_rf_wdata;

    assign w_run  = (current_state == RD_DATA);
    assign w_xfer = r_mem_req && bus.mem_ack;

    rd_addr_cnt #(
        .ADDR_W    (ADDR_W),
        .NUM_WORDS (NUM_WORDS)
    ) u_addr_cnt (
        .clk     (clk),
        .rst     (rst),
        .i_clr   (w_cnt_clr),
        .i_en    (w_cnt_en),
        .o_count (w_count),
        .o_tc    (w_tc)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_req_nxt   = 1'b0;
        w_done_nxt  = 1'b0;
        w_cnt_clr   = 1'b0;
        w_cnt_en    = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_cnt_clr = 1'b1;
                if (w_run) begin
                    w_state_nxt = S_FETCH;
                    w_req_nxt   = 1'b1;
                end
            end
            S_FETCH: begin
                w_cnt_en = w_xfer;
                // Abort takes priority: the controller has moved on, so no rd_done.
                if (!w_run) begin
                    w_state_nxt = S_IDLE;
                    w_cnt_clr   = 1'b1;
                end else if (w_xfer && w_tc) begin
                    w_state_nxt = S_DONE;
                    w_cnt_clr   = 1'b1;
                    w_done_nxt  = 1'b1;
                end else begin
                    w_req_nxt   = 1'b1;
                end
            end
            S_DONE: begin
                w_state_nxt = S_HOLD;
            end
            S_HOLD: begin
                if (!w_run) begin
                    w_state_nxt = S_IDLE;
                    w_cnt_clr   = 1'b1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // A write is issued one cycle after every accepted word, including an
    // ack taken in an abort cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mem_req  <= 1'b0;
            r_rd_done  <= 1'b0;
            r_rf_we    <= 1'b0;
            r_rf_waddr <= '0;
            r_rf_wdata <= '0;
        end else begin
            r_mem_req <= w_req_nxt;
            r_rd_done <= w_done_nxt;
            r_rf_we   <= w_xfer;
            if (w_xfer) begin
                r_rf_waddr <= w_count;
                r_rf_wdata <= bus.mem_rdata;
            end
        end
    end

    assign bus.mem_req  = r_mem_req;
    assign bus.mem_addr = w_count;
    assign bus.rf_we    = r_rf_we;
    assign bus.rf_waddr = r_rf_waddr;
    assign bus.rf_wdata = r_rf_wdata;
    assign rd_done      = r_rd_done;

`ifdef RD_DATA_CHECKSUM_EN
    logic [DATA_W-1:0] r_chk_sum;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_chk_sum <= '0;
        end else if ((r_state == S_IDLE) && w_run) begin
            r_chk_sum <= '0;
        end else if (w_xfer) begin
            r_chk_sum <= r_chk_sum + bus.mem_rdata;
        end
    end

    assign chk_sum = r_chk_sum;
`endif
endmodule
`default_nettype wire

// File: tb/tb_rd_data_ctr.sv
`default_nettype none
// ============================================================================
// Module      : tb_rd_data_ctr
// Description : Randomized self-checking bench for rd_data_ctr against a
//               transaction-level model of the read phase.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rd_data_ctr;
    import ec_ctr_pkg::*;

    localparam int DATA_W    = 8;
    localparam int NUM_WORDS = 16;
    localparam int ADDR_W    = 4;

    logic              clk;
    logic              rst;
    logic [2:0]        current_state;
    logic              rd_done;
`ifdef RD_DATA_CHECKSUM_EN
    logic [DATA_W-1:0] chk_sum;
`endif

    rd_data_ctr_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    rd_data_ctr #(
        .DATA_W    (DATA_W),
        .NUM_WORDS (NUM_WORDS),
        .ADDR_W    (ADDR_W)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .current_state (current_state),
        .bus           (bus),
        .rd_done       (rd_done)
`ifdef RD_DATA_CHECKSUM_EN
        ,
        .chk_sum       (chk_sum)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int                n_tests  = 0;
    int                n_fail   = 0;
    int                k        = 0;   // words accepted so far in this phase
    int                n_writes = 0;
    int                n_done   = 0;
    int                n_req    = 0;
    int                n_acks   = 0;
    logic              got_done = 1'b0;
    logic              prev_req = 1'b0;
    logic [DATA_W-1:0] m_sum    = '0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One clock: apply inputs, predict the next cycle from the word-level rules,
    // then compare just after the edge.
    task automatic tick(input logic [2:0] cs, input logic ack, input logic [DATA_W-1:0] rd, input logic r);
        logic              m_we;
        logic              m_done;
        logic [ADDR_W-1:0] m_waddr;
        logic [DATA_W-1:0] m_wdata;
        logic              req;
        m_we    = 1'b0;
        m_done  = 1'b0;
        m_waddr = '0;
        m_wdata = '0;
        current_state = cs;
        bus.mem_ack   = ack;
        bus.mem_rdata = rd;
        rst           = r;
        req = (bus.mem_req === 1'b1);
        if (req) begin
            n_req++;
            check_val("mem_addr", 32'(bus.mem_addr), 32'(k));
            if (!prev_req) m_sum = '0;
        end
        prev_req = req;
        if (r) begin
            k     = 0;
            m_sum = '0;
        end else if (req) begin
            if (ack) begin
                m_we    = 1'b1;
                m_waddr = ADDR_W'(k);
                m_wdata = rd;
                m_sum   = m_sum + rd;
                k++;
                n_acks++;
            end
            if (cs != RD_DATA) begin
                k = 0;
            end else if (k == NUM_WORDS) begin
                m_done = 1'b1;
                k      = 0;
            end
        end
        @(posedge clk);
        #1;
        check_val("rf_we", 32'(bus.rf_we), 32'(m_we));
        check_val("rd_done", 32'(rd_done), 32'(m_done));
        if (m_we || r) begin
            check_val("rf_waddr", 32'(bus.rf_waddr), 32'(m_waddr));
            check_val("rf_wdata", 32'(bus.rf_wdata), 32'(m_wdata));
        end
        if (r) begin
            check_val("rst_mem_req", 32'(bus.mem_req), 32'(0));
            check_val("rst_mem_addr", 32'(bus.mem_addr), 32'(0));
        end
`ifdef RD_DATA_CHECKSUM_EN
        if (r || rd_done === 1'b1) check_val("chk_sum", 32'(chk_sum), 32'(m_sum));
`endif
        if (bus.rf_we === 1'b1) n_writes++;
        if (rd_done === 1'b1) begin
            n_done++;
            got_done = 1'b1;
        end
    endtask

    // ack_mode: 0 tied high, 1 every third cycle, else random.
    // data_mode: 0 addr+0x10, 1 random, 2 addr+0xF0, else zero.
    task automatic run_phase(input int ack_mode, input int data_mode, input int budget);
        logic              a;
        logic [DATA_W-1:0] d;
        n_writes = 0;
        n_done   = 0;
        n_req    = 0;
        got_done = 1'b0;
        for (int c = 0; c < budget && !got_done; c++) begin
            case (ack_mode)
                0:       a = 1'b1;
                1:       a = (c % 3 == 2);
                default: a = 1'($urandom_range(0, 1));
            endcase
            case (data_mode)
                0:       d = DATA_W'(bus.mem_addr) + 8'h10;
                1:       d = DATA_W'($urandom);
                2:       d = DATA_W'(bus.mem_addr) + 8'hF0;
                default: d = '0;
            endcase
            tick(RD_DATA, a, d, 1'b0);
        end
        check_val("phase_done_seen", 32'(got_done), 32'(1));
        check_val("phase_writes", 32'(n_writes), 32'(NUM_WORDS));
        check_val("phase_done_cnt", 32'(n_done), 32'(1));
    endtask

    task automatic leave_phase();
        repeat (2) tick(GENERATE_IND, 1'b0, '0, 1'b0);
    endtask

    initial begin
        current_state = IDLE;
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = '0;
        rst           = 1'b1;

        repeat (3) tick(IDLE, 1'b0, '0, 1'b1);
        tick(IDLE, 1'b1, 8'hAA, 1'b0);
        check_val("idle_no_req", 32'(bus.mem_req), 32'(0));

        // Full phase with ack tied high.
        run_phase(0, 0, 40);
        check_val("req_cycles", 32'(n_req), 32'(NUM_WORDS));

        // Controller lingers in RD_DATA: no re-trigger.
        n_req = 0;
        repeat (10) tick(RD_DATA, 1'($urandom_range(0, 1)), DATA_W'($urandom), 1'b0);
        check_val("hold_no_req", 32'(n_req), 32'(0));
        tick(GENERATE_IND, 1'b0, '0, 1'b0);

        // Stalled memory, new phase starting at address 0.
        run_phase(1, 1, 100);
        leave_phase();

        // Abort after 5 acks.
        n_writes = 0;
        n_done   = 0;
        n_acks   = 0;
        for (int c = 0; c < 40 && n_acks < 5; c++) tick(RD_DATA, 1'b1, DATA_W'($urandom), 1'b0);
        check_val("abort_acks", 32'(n_acks), 32'(5));
        tick(GENERATE_IND, 1'b0, '0, 1'b0);
        check_val("abort_req_drop", 32'(bus.mem_req), 32'(0));
        tick(GENERATE_IND, 1'b0, '0, 1'b0);
        check_val("abort_writes", 32'(n_writes), 32'(5));
        check_val("abort_no_done", 32'(n_done), 32'(0));

        // Reset on the cycle of the 8th ack.
        n_writes = 0;
        n_acks   = 0;
        for (int c = 0; c < 40 && n_acks < 7; c++) tick(RD_DATA, 1'b1, DATA_W'($urandom), 1'b0);
        check_val("rst_acks", 32'(n_acks), 32'(7));
        tick(RD_DATA, 1'b1, DATA_W'($urandom), 1'b1);
        check_val("rst_writes", 32'(n_writes), 32'(7));
        run_phase(2, 1, 200);
        leave_phase();

        repeat (3) begin
            run_phase(2, 1, 200);
            leave_phase();
        end

`ifdef RD_DATA_CHECKSUM_EN
        run_phase(0, 2, 40);
        check_val("chk_sum_f0", 32'(chk_sum), 32'(8'h78));
        leave_phase();
        run_phase(2, 3, 200);
        check_val("chk_sum_zero", 32'(chk_sum), 32'(0));
        leave_phase();
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
